// File: rtl/dut_test_sequencer.sv
// dut_test_sequencer: drives the BRAM power-test DUT through a fixed
// lead -> run -> stop sequence and judges its per-bank pass flags.
// Every output is registered. The results (fail count, first fail,
// verdict, aborted) are held in DONE until the next rising edge of go.
module dut_test_sequencer #(
  parameter int EN_LEAD       = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int RUN_CYCLES    = 64
) (
  input  logic        ref_clk_in,
  input  logic        reset,
  input  logic        go_in,
  input  logic        abort_in,
  input  logic [1:0]  fmc_in,
  output logic        clock_en_out,
  output logic        start_out,
  output logic        stop_out,
  output logic        done_out,
  output logic        verdict_out,
  output logic        aborted_out,
  output logic [15:0] fail_count_out,
  output logic [1:0]  first_fail_out
);

  localparam logic [15:0] LP_LEAD_LAST = 16'(EN_LEAD - 1);
  localparam logic [15:0] LP_RUN_LAST  = 16'(RUN_CYCLES - 1);
  localparam logic [15:0] LP_SETTLE    = 16'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_RUN,
    S_STOP,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_go_d;
  logic [15:0] r_cnt;      // LEAD cycle count, then the run index in RUN

  logic        w_go_rise;
  logic        w_fail;

  assign w_go_rise = go_in & ~r_go_d;
  // A run cycle fails only once the DUT has settled and a bank reports failure.
  assign w_fail    = (r_state == S_RUN) && (r_cnt >= LP_SETTLE) && (fmc_in != 2'b11);

  // Delayed copy of go_in, so a held-high go cannot retrigger a sequence.
  always_ff @(posedge ref_clk_in or posedge reset) begin
    if (reset) r_go_d <= 1'b0;
    else       r_go_d <= go_in;
  end

  // Sequencer FSM with registered control outputs and result accumulation.
  always_ff @(posedge ref_clk_in or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      clock_en_out   <= 1'b0;
      start_out      <= 1'b0;
      stop_out       <= 1'b0;
      done_out       <= 1'b0;
      verdict_out    <= 1'b0;
      aborted_out    <= 1'b0;
      fail_count_out <= '0;
      first_fail_out <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_go_rise) begin
            r_state        <= S_LEAD;
            r_cnt          <= '0;
            clock_en_out   <= 1'b1;
            start_out      <= 1'b0;
            stop_out       <= 1'b0;
            done_out       <= 1'b0;
            verdict_out    <= 1'b0;
            aborted_out    <= 1'b0;
            fail_count_out <= '0;
            first_fail_out <= '0;
          end
        end

        S_LEAD: begin
          if (abort_in) begin
            r_state     <= S_STOP;
            stop_out    <= 1'b1;
            aborted_out <= 1'b1;
          end else if (r_cnt == LP_LEAD_LAST) begin
            r_state   <= S_RUN;
            r_cnt     <= '0;
            start_out <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_RUN: begin
          // The current cycle still counts even when abort ends the run.
          if (w_fail) begin
            if (fail_count_out != 16'hFFFF) fail_count_out <= fail_count_out + 16'd1;
            if (fail_count_out == 16'd0)    first_fail_out <= ~fmc_in;
          end
          if (abort_in) begin
            r_state     <= S_STOP;
            start_out   <= 1'b0;
            stop_out    <= 1'b1;
            aborted_out <= 1'b1;
          end else if (r_cnt == LP_RUN_LAST) begin
            r_state   <= S_STOP;
            start_out <= 1'b0;
            stop_out  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_STOP: begin
          // The fail count is final here; no counting happens outside RUN.
          r_state      <= S_DONE;
          clock_en_out <= 1'b0;
          stop_out     <= 1'b0;
          done_out     <= 1'b1;
          verdict_out  <= (fail_count_out == 16'd0) & ~aborted_out;
        end

        default: begin
          r_state      <= S_IDLE;
          clock_en_out <= 1'b0;
          start_out    <= 1'b0;
          stop_out     <= 1'b0;
          done_out     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dut_test_sequencer.sv
// Directed bench for dut_test_sequencer with default parameters
// (EN_LEAD=4, SETTLE_CYCLES=8, RUN_CYCLES=64).
// Edge 0 is the edge that samples the go rise. After edge k the
// controls are expected as follows: clock_en for k <= last, start for
// 4 <= k < last, stop at k == last, done for k > last. Here last = 68,
// or the edge that sampled abort. Run index i is sampled at edge i+5.
module tb_dut_test_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        go_in;
  logic        abort_in;
  logic [1:0]  fmc_in;
  logic        clock_en_out, start_out, stop_out, done_out;
  logic        verdict_out, aborted_out;
  logic [15:0] fail_count_out;
  logic [1:0]  first_fail_out;

  int checks = 0;
  int errors = 0;

  dut_test_sequencer dut (
    .ref_clk_in     (clk),
    .reset          (reset),
    .go_in          (go_in),
    .abort_in       (abort_in),
    .fmc_in         (fmc_in),
    .clock_en_out   (clock_en_out),
    .start_out      (start_out),
    .stop_out       (stop_out),
    .done_out       (done_out),
    .verdict_out    (verdict_out),
    .aborted_out    (aborted_out),
    .fail_count_out (fail_count_out),
    .first_fail_out (first_fail_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {9'd0, clock_en_out, start_out, stop_out, done_out, verdict_out,
            aborted_out, fail_count_out, first_fail_out};
  endfunction

  // Stimulus modes for fmc_in as a function of the run index:
  //   0: always 11
  //   1: 10 at indices 20..22
  //   2: 00 at indices 0..7 (settle window only)
  //   3: 00 at indices 0..8
  function automatic logic [1:0] fmc_pat(input int mode, input int idx);
    case (mode)
      1: return (idx >= 20 && idx <= 22) ? 2'b10 : 2'b11;
      2: return (idx >= 0 && idx <= 7) ? 2'b00 : 2'b11;
      3: return (idx >= 0 && idx <= 8) ? 2'b00 : 2'b11;
      default: return 2'b11;
    endcase
  endfunction

  // Runs one sequence from a go rise. Checks the controls at every edge and
  // checks the held results at the end. abort_at < 0 means no abort.
  task automatic do_seq(input string name, input int mode, input int abort_at,
                        input bit hold_go, input logic [15:0] exp_fc,
                        input logic [1:0] exp_ff, input bit exp_v, input bit exp_ab);
    int last;
    last = (abort_at >= 0) ? abort_at : 68;
    for (int k = 0; k <= 71; k++) begin
      go_in    = (k == 0) ? 1'b1 : hold_go;
      abort_in = (k == abort_at);
      fmc_in   = fmc_pat(mode, k - 5);
      tick();
      chk($sformatf("%s ctl k%0d", name, k),
          {28'd0, clock_en_out, start_out, stop_out, done_out},
          {28'd0, (k <= last), (k >= 4 && k < last), (k == last), (k > last)});
      if (k == 0) chk($sformatf("%s cleared", name),
                      {13'd0, verdict_out, aborted_out, fail_count_out, first_fail_out}, 32'd0);
      if (mode == 1 && k == 24) chk($sformatf("%s fc k24", name), 32'(fail_count_out), 32'd0);
      if (mode == 1 && k == 25) chk($sformatf("%s fc k25", name), 32'(fail_count_out), 32'd1);
    end
    abort_in = 1'b0;
    fmc_in   = 2'b11;
    chk($sformatf("%s fail_count", name), 32'(fail_count_out), 32'(exp_fc));
    chk($sformatf("%s first_fail", name), 32'(first_fail_out), 32'(exp_ff));
    chk($sformatf("%s verdict", name), 32'(verdict_out), 32'(exp_v));
    chk($sformatf("%s aborted", name), 32'(aborted_out), 32'(exp_ab));
  endtask

  initial begin
    reset    = 1'b1;
    go_in    = 1'b0;
    abort_in = 1'b0;
    fmc_in   = 2'b11;
    tick();
    tick();
    chk("reset outs", all_outs(), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle outs", all_outs(), 32'd0);

    // Clean run.
    do_seq("clean", 0, -1, 1'b0, 16'd0, 2'b00, 1'b1, 1'b0);

    // Three failing cycles; go is then held high through DONE.
    do_seq("fail3", 1, -1, 1'b1, 16'd3, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("hold done", 32'(done_out), 32'd1);
    chk("hold ce", 32'(clock_en_out), 32'd0);
    chk("hold fc", 32'(fail_count_out), 32'd3);
    go_in = 1'b0;
    tick();
    chk("go low fc", 32'(fail_count_out), 32'd3);

    // Failures confined to the settle window are ignored; index 8 counts.
    do_seq("settle", 2, -1, 1'b0, 16'd0, 2'b00, 1'b1, 1'b0);
    do_seq("idx8", 3, -1, 1'b0, 16'd1, 2'b11, 1'b0, 1'b0);

    // Abort sampled at edge 30, mid-run.
    do_seq("abort", 0, 30, 1'b0, 16'd0, 2'b00, 1'b0, 1'b1);

    // Asynchronous reset mid-run.
    go_in = 1'b1;
    tick();
    go_in = 1'b0;
    for (int k = 1; k <= 39; k++) tick();
    chk("pre-reset run", {30'd0, clock_en_out, start_out}, 32'd3);
    #2 reset = 1'b1;
    #1 chk("async reset", all_outs(), 32'd0);
    #1 reset = 1'b0;
    do_seq("post-reset", 0, -1, 1'b0, 16'd0, 2'b00, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
